// File: rtl/router_pkg.sv
// Shared types and helpers for the router output-port scheduler.
// Holds the FSM state encoding, default geometry and the dest-field extractor.
package router_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_ADDR_W = 2;
    localparam int DEF_N_REQ  = 4;

    localparam int MAX_WIDTH  = 64;
    localparam int MAX_ADDR_W = 8;

    // Destination lives in the top addr_w bits of a width-bit header beat.
    function automatic logic [MAX_ADDR_W-1:0] dest_field(
        input logic [MAX_WIDTH-1:0] beat,
        input int                   width,
        input int                   addr_w
    );
        logic [MAX_WIDTH-1:0]  sh;
        logic [MAX_ADDR_W-1:0] mask;
        sh   = beat >> (width - addr_w);
        mask = '1;
        mask = mask >> (MAX_ADDR_W - addr_w);
        return sh[MAX_ADDR_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/router_port_scheduler_if.sv
// Requester-side and output-link handshake bundle for one router output port.
// master drives requests and downstream ready; slave is the scheduler.
interface router_port_scheduler_if
    import router_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_REQ = DEF_N_REQ
) ();
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic                   out_ready;
    logic [N_REQ-1:0]       grant;
    logic                   busy;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, grant, busy
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, grant, busy
    );
endinterface

// File: rtl/comparatorEquall.sv
// Equality comparator; result is 1 when a and b differ.
// Latency: combinational.
// Backpressure: none (no handshake).
module comparatorEquall #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             result
);
    assign result = (a != b);
endmodule

// File: rtl/router_port_scheduler_rr_picker.sv
// Round-robin picker: first set bit of match strictly after last_ptr, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the pick.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] match,
    input  logic [PTR_W-1:0] last_ptr,
    output logic [N_REQ-1:0] pick,
    output logic [PTR_W-1:0] pick_idx
);
    logic found;
    int   idx;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_ptr) + k) % N_REQ;
            if (!found && match[idx]) begin
                found     = 1'b1;
                pick[idx] = 1'b1;
                pick_idx  = PTR_W'(idx);
            end
        end
    end
endmodule

// File: rtl/router_port_scheduler.sv
// Output-port scheduler: round-robin grant of fixed-length packets addressed to PORT_ADDR.
// Latency: 1 cycle arbitration in IDLE, then zero-latency combinational data pass-through.
// Backpressure: out_ready is forwarded to the owner's req_ready; stalls hold grant and count.
module router_port_scheduler
    import router_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int N_REQ     = DEF_N_REQ,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int PORT_ADDR = 0,
    parameter int PKT_LEN   = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    router_port_scheduler_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(PKT_LEN + 1);

    state_t           state;
    logic [N_REQ-1:0] grant_q;
    logic [PTR_W-1:0] gidx;
    logic [PTR_W-1:0] last_ptr;
    logic [CNT_W-1:0] beat_cnt;
    logic             busy_q;

    logic [N_REQ-1:0] mismatch;
    logic [N_REQ-1:0] match;
    logic [N_REQ-1:0] pick;
    logic [PTR_W-1:0] pick_idx;
    logic             hs;

    for (genvar i = 0; i < N_REQ; i++) begin : g_cmp
        logic [ADDR_W-1:0] dst;
        assign dst = ADDR_W'(dest_field(MAX_WIDTH'(bus.req_data[i*WIDTH +: WIDTH]), WIDTH, ADDR_W));
        comparatorEquall #(.WIDTH(ADDR_W)) u_cmp (
            .a      (dst),
            .b      (ADDR_W'(PORT_ADDR)),
            .result (mismatch[i])
        );
    end

    assign match = bus.req_valid & ~mismatch;

    rr_picker #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
        .match    (match),
        .last_ptr (last_ptr),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    // Datapath is steered purely by the registered owner, so a stalled owner keeps the link.
    assign bus.out_valid = (state == XFER) && |(grant_q & bus.req_valid);
    assign bus.out_data  = (state == XFER) ? bus.req_data[int'(gidx)*WIDTH +: WIDTH] : '0;
    assign bus.req_ready = ((state == XFER) && bus.out_ready) ? grant_q : '0;
    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign hs            = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_q  <= '0;
            gidx     <= '0;
            busy_q   <= 1'b0;
            beat_cnt <= '0;
            last_ptr <= PTR_W'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|match) begin
                        grant_q  <= pick;
                        gidx     <= pick_idx;
                        beat_cnt <= '0;
                        busy_q   <= 1'b1;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (hs) begin
                        if (beat_cnt == CNT_W'(PKT_LEN - 1)) begin
                            last_ptr <= gidx;
                            grant_q  <= '0;
                            busy_q   <= 1'b0;
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
